// File: rtl/tagv_array.sv
// Multi-way tag/valid store: synchronous write-first read port with per-way tag compare,
// and a sweep FSM that clears every valid bit after reset and on invalidate-all.
module tagv_array #(
  parameter int TAG_WIDTH = 20,
  parameter int DEPTH     = 64,
  parameter int WAYS      = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           inv_all,
  output logic                           ready,
  input  logic                           rd_en,
  input  logic [$clog2(DEPTH)-1:0]       raddr,
  input  logic [TAG_WIDTH-1:0]           rtag,
  output logic [WAYS*(TAG_WIDTH+1)-1:0]  rdata,
  output logic [WAYS-1:0]                hit,
  input  logic                           we,
  input  logic [$clog2(DEPTH)-1:0]       waddr,
  input  logic [WAYS-1:0]                wway,
  input  logic [TAG_WIDTH-1:0]           wtag,
  input  logic                           wvalid
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam int EW         = TAG_WIDTH + 1;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WAYS*EW-1:0]      rdata_q, rdata_d;
  logic [TAG_WIDTH-1:0]    rtag_q, rtag_d;

  logic [EW-1:0]           mem [WAYS][DEPTH];
  logic [WAYS-1:0]         mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [EW-1:0]           mem_wdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    rtag_d    = rtag_q;
    mem_we    = '0;
    mem_addr  = waddr;
    mem_wdata = {wvalid, wtag};
    case (state_q)
      ST_CLEAR: begin
        // Sweep owns the write port; user reads and writes are dropped.
        mem_we    = rst ? '0 : '1;
        mem_addr  = cnt_q;
        mem_wdata = '0;
        if (inv_all) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_READY;
        end
      end
      default: begin
        mem_we = (we && !rst) ? wway : '0;
        if (rd_en) begin
          rtag_d = rtag;
          for (int w = 0; w < WAYS; w++) begin
            if (we && wway[w] && (raddr == waddr))
              rdata_d[w*EW +: EW] = {wvalid, wtag};
            else
              rdata_d[w*EW +: EW] = mem[w][raddr];
          end
        end
        if (inv_all) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      rdata_q <= '0;
      rtag_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rtag_q  <= rtag_d;
    end
  end

  // Array storage has no reset; the sweep provides the known contents.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (mem_we[w]) mem[w][mem_addr] <= mem_wdata;
    end
  end

  assign ready = (state_q == ST_READY);
  assign rdata = rdata_q;

  always_comb begin
    hit = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit[w] = ready && rdata_q[w*EW + TAG_WIDTH] && (rdata_q[w*EW +: TAG_WIDTH] == rtag_q);
    end
  end

endmodule

// File: doc/tagv_array.md
Name: tagv_array

Overview:
Parametrised multi-way tag/valid store for the L1 caches; successor to the single-way tag RAM.
- Holds WAYS tag+valid entries per set, with a synchronous read port and a per-way write port.
- Read port has write-first forwarding and a built-in tag comparator that produces a per-way hit vector.
- A hardware sweep FSM clears every valid bit after reset and on an invalidate-all request, so the array needs no initial/readmem contents.

Parameters:
TAG_WIDTH, 20, tag bits per way; stored entry is TAG_WIDTH+1 bits, valid in the MSB.
DEPTH, 64, sets per way; power of two, at least 2.
WAYS, 2, number of ways, at least 1.
ADDR_WIDTH, log2(DEPTH), derived index width; localparam, not overridable.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
inv_all  in  1  pulse: request invalidate-all sweep.
ready  out  1  array usable; 0 while sweeping.
rd_en  in  1  read request.
raddr  in  ADDR_WIDTH  read set index.
rtag  in  TAG_WIDTH  tag to compare; sampled together with raddr.
rdata  out  WAYS*(TAG_WIDTH+1)  registered entries; way w at [w*(TAG_WIDTH+1) +: TAG_WIDTH+1].
hit  out  WAYS  per-way hit for the last accepted read.
we  in  1  write enable.
waddr  in  ADDR_WIDTH  write set index.
wway  in  WAYS  way-select mask; any combination is allowed.
wtag  in  TAG_WIDTH  tag to write.
wvalid  in  1  valid bit to write.

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset values:
  - ready=0, rdata=0, hit=0.
  - FSM=CLEAR, sweep counter=0, captured rtag register=0.
  - The array itself is not touched on the reset edge.
- FSM states:
  - CLEAR: each edge writes {valid=0, tag=0} to set cnt in every way, then cnt increments. On the edge where cnt==DEPTH-1, the FSM moves to READY.
  - READY: ready=1. inv_all=1 goes to CLEAR with cnt=0 on the next edge.
- Sweep timing: after rst deasserts, ready rises after exactly DEPTH edges.
- inv_all during CLEAR restarts the sweep at cnt=0. rst mid-sweep also restarts it, with outputs forced to their reset values.
- While in CLEAR:
  - we and rd_en are ignored; no array write, rdata holds.
  - hit is forced to 0.
- Read, 1-cycle latency:
  - An edge with rd_en=1 in READY loads rdata from the array at raddr and captures rtag.
  - With rd_en=0, rdata and the captured tag hold. A held rdata is NOT updated by later writes.
- Write: an edge with we=1 in READY writes {wvalid, wtag} to set waddr for every way w with wway[w]=1. Other ways are untouched. wway=0 is a no-op.
- Same-edge read and write, write-first:
  - If rd_en & we & raddr==waddr, the ways selected by wway load rdata with {wvalid, wtag}.
  - Unselected ways load the old array contents.
  - A differing address has no interaction.
- hit is combinational from registered state:
  - hit[w] = ready & rdata_valid[w] & (rdata_tag[w] == captured rtag).
  - More than one hit bit may be set; this block does not check for multi-hit.
- rdata is valid only while ready=1. After a sweep completes, rdata holds its pre-sweep value until the next read, but hit stays qualified by ready.
- The sweep covers indices 0..DEPTH-1 exactly once, with no wrap past DEPTH-1. cnt is ADDR_WIDTH bits wide.

Test Plan:
1. Reset and sweep: hold rst 3 cycles, then release with DEPTH=64. Required: ready=0 for 63 edges and 1 after the 64th. A read of every set then returns rdata=0 and hit=0.
2. Basic write/read with WAYS=2, TAG_WIDTH=20:
   - Write set 5, way0, tag 0x12345, valid=1.
   - Next cycle read set 5 with rtag=0x12345. Required: way0 field=0x112345, way1=0, hit=2'b01.
   - Repeat with rtag=0x12346. Required: hit=2'b00.
3. Forwarding:
   - Set 9 way1 holds tag 0xABCDE, valid=1.
   - On the same edge: write set 9 with wway=2'b10, tag 0x00001, plus a read of set 9 with rtag=0x00001.
   - Required: way1 field=0x100001, hit=2'b10. Also read set 8 in the same scenario; it must show no forwarding.
4. Invalidate-all:
   - Fill sets 0..63 with valid entries, pulse inv_all.
   - Required: ready=0 for 64 cycles, reads and writes issued during that window are ignored, afterwards all hit=0.
   - Pulse inv_all again at cnt=30. Required: the sweep restarts and ready returns 64 edges after the second pulse.
5. Hold behaviour: read set 3 (hit=01), then drive rd_en=0 and write set 3 way0 valid=0. Required: rdata and hit unchanged until the next rd_en=1.
6. Reset mid-sweep: assert rst at cnt=40. Required: rdata=0, hit=0, ready=0, and the full 64-edge sweep after release.
